mem_word_display: RTL and testbench

- Consumer end of the 8-bit display-address stream produced by the speed/pause address controller.
- addr[7] selects the memory: 0 = instruction, 1 = data. addr[6:0] selects one of 128 words.
- The block reads the selected 32-bit word from synchronous-read memory, holds it, and time-multiplexes it as 8 hex digits onto an active-low 7-segment display.
- Sits between the address controller, the two memories and the board display pins.

---
 rtl/mem_word_display_if.sv | 25 ++
 rtl/mem_word_display.sv | 148 ++++++++++++++
 tb/tb_mem_word_display.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_word_display_if.sv
// Read port shared by the display reader and the instruction/data memories.
// The reader drives the strobe and address; both memories return their words.
interface mem_word_display_if;
  logic        mem_rd_en;
  logic        mem_sel;
  logic [6:0]  mem_addr;
  logic [31:0] instr_rdata;
  logic [31:0] data_rdata;

  modport master (
    output mem_rd_en,
    output mem_sel,
    output mem_addr,
    input  instr_rdata,
    input  data_rdata
  );

  modport slave (
    input  mem_rd_en,
    input  mem_sel,
    input  mem_addr,
    output instr_rdata,
    output data_rdata
  );
endinterface

// File: rtl/mem_word_display.sv
// Fetches the 32-bit word at the display address from instruction or data memory
// and scans it as 8 hex digits onto an active-low 7-segment display.
module mem_word_display #(
  parameter int SCAN_DIV = 100000,
  parameter int RD_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                addr,
  mem_word_display_if.master        mem_bus,
  output logic [7:0]                shown_addr,
  output logic [7:0]                anode,
  output logic [6:0]                cathode,
  output logic                      dp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  localparam int         CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0] LAST_LAT = 2'(RD_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic             pending_q, pending_d;
  logic             rd_en_q, rd_en_d;
  logic             sel_q, sel_d;
  logic [6:0]       maddr_q, maddr_d;
  logic [1:0]       lat_q, lat_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       shown_q, shown_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       cath_q, cath_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Reads are never aborted: address changes are only looked at from IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rd_en_d   = 1'b0;
    sel_d     = sel_q;
    maddr_d   = maddr_q;
    lat_d     = lat_q;
    word_d    = word_q;
    shown_d   = shown_q;
    case (state_q)
      S_IDLE: begin
        if (pending_q || (addr != shown_q)) begin
          sel_d     = addr[7];
          maddr_d   = addr[6:0];
          rd_en_d   = 1'b1;
          pending_d = 1'b0;
          lat_d     = 2'd0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAST_LAT) begin
          state_d = S_CAPT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_CAPT: begin
        word_d  = sel_q ? mem_bus.data_rdata : mem_bus.instr_rdata;
        shown_d = {sel_q, maddr_q};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Free-running digit scanner; display registers sample the current word each cycle.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end
    anode_d = ~(8'b1 << idx_q);
    cath_d  = hex7(word_q[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b1;
      rd_en_q   <= 1'b0;
      sel_q     <= 1'b0;
      maddr_q   <= 7'd0;
      lat_q     <= 2'd0;
      word_q    <= 32'd0;
      shown_q   <= 8'd0;
      scan_q    <= '0;
      idx_q     <= 3'd0;
      anode_q   <= 8'hFF;
      cath_q    <= 7'h7F;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rd_en_q   <= rd_en_d;
      sel_q     <= sel_d;
      maddr_q   <= maddr_d;
      lat_q     <= lat_d;
      word_q    <= word_d;
      shown_q   <= shown_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cath_q    <= cath_d;
    end
  end

  assign mem_bus.mem_rd_en = rd_en_q;
  assign mem_bus.mem_sel   = sel_q;
  assign mem_bus.mem_addr  = maddr_q;
  assign shown_addr        = shown_q;
  assign anode             = anode_q;
  assign cathode           = cath_q;
  assign dp                = 1'b1;

endmodule

// File: tb/tb_mem_word_display.sv
// Two readers (read latency 1 and 3) share one address stream; a negedge monitor
// checks reads, shown address and the scanned display against a reference model.
module tb_mem_word_display;
  localparam int SCAN_DIV = 4;
  localparam int NI       = 2;

  // Active-low {g..a} patterns, digit 0 in the low 7 bits.
  localparam logic [111:0] SEG_TBL = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'd0;
  logic       rst_s = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) rst_s <= rst;

  logic [31:0] instr_mem [128];
  logic [31:0] data_mem  [128];

  logic [7:0] shown_w [NI];
  logic [7:0] anode_w [NI];
  logic [6:0] cath_w  [NI];
  logic       dp_w    [NI];
  logic       rden_w  [NI];
  logic       sel_w   [NI];
  logic [6:0] maddr_w [NI];

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    mem_word_display_if bus ();
    logic [8:0] dly [4];
    logic [8:0] cur;
    logic [8:0] tap;

    assign cur = {bus.mem_rd_en, bus.mem_sel, bus.mem_addr};
    assign tap = (LAT == 1) ? cur : dly[(LAT >= 2) ? LAT - 2 : 0];

    // Memory model: data for a strobe appears LAT edges after the strobe is sampled.
    always @(posedge clk) begin
      dly[0] <= cur;
      dly[1] <= dly[0];
      dly[2] <= dly[1];
      dly[3] <= dly[2];
      if (tap[8] === 1'b1) begin
        if (tap[7]) bus.data_rdata  <= data_mem[tap[6:0]];
        else        bus.instr_rdata <= instr_mem[tap[6:0]];
      end
    end

    mem_word_display #(.SCAN_DIV(SCAN_DIV), .RD_LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .mem_bus    (bus.master),
      .shown_addr (shown_w[g]),
      .anode      (anode_w[g]),
      .cathode    (cath_w[g]),
      .dp         (dp_w[g])
    );

    assign rden_w[g]  = bus.mem_rd_en;
    assign sel_w[g]   = bus.mem_sel;
    assign maddr_w[g] = bus.mem_addr;
  end

  // Scoreboard: expected read addresses, consumed independently by each reader.
  logic [7:0] exp_rd [$];
  int         ridx      [NI];
  int         k         [NI];
  int         cd        [NI];
  int         last_wrap [NI];
  logic [7:0] mshown    [NI];
  logic [7:0] cap_a     [NI];
  logic [7:0] prev_an   [NI];
  logic [31:0] disp_w   [NI];
  logic [31:0] stage_w  [NI];
  bit          stage_v  [NI];

  int errors = 0;
  int checks = 0;
  bit done = 1'b0;
  bit fin  = 1'b0;

  int         idx;
  logic [7:0] exp_an;
  logic [3:0] nib;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[lat%0d] at %0t: got %0h expected %0h", nm, lat_of(g), $time, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return a[7] ? data_mem[a[6:0]] : instr_mem[a[6:0]];
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rst_s) begin
        chk("rst_rd_en", g, rden_w[g], 0);
        chk("rst_sel", g, sel_w[g], 0);
        chk("rst_mem_addr", g, maddr_w[g], 0);
        chk("rst_shown", g, shown_w[g], 0);
        chk("rst_anode", g, anode_w[g], 8'hFF);
        chk("rst_cathode", g, cath_w[g], 7'h7F);
        chk("rst_dp", g, dp_w[g], 1);
        k[g] = 0; cd[g] = 0; mshown[g] = 8'd0; disp_w[g] = 32'd0;
        stage_v[g] = 1'b0; prev_an[g] = 8'hFF; last_wrap[g] = -1;
      end else begin
        k[g]++;
        if (stage_v[g]) begin
          disp_w[g] = stage_w[g];
          stage_v[g] = 1'b0;
        end
        idx    = ((k[g] - 1) / SCAN_DIV) % 8;
        exp_an = ~(8'd1 << idx);
        nib    = disp_w[g][4*idx +: 4];
        chk("anode", g, anode_w[g], exp_an);
        chk("cathode", g, cath_w[g], SEG_TBL[7*nib +: 7]);
        chk("dp", g, dp_w[g], 1);
        if (anode_w[g] == 8'hFE && prev_an[g] == 8'h7F) begin
          if (last_wrap[g] >= 0) chk("wrap_period", g, k[g] - last_wrap[g], 8 * SCAN_DIV);
          last_wrap[g] = k[g];
        end
        prev_an[g] = anode_w[g];
        if (cd[g] > 0) begin
          cd[g]--;
          if (cd[g] == 0) begin
            mshown[g]  = cap_a[g];
            stage_w[g] = word_of(cap_a[g]);
            stage_v[g] = 1'b1;
          end
        end
        chk("shown_addr", g, shown_w[g], mshown[g]);
        if (k[g] == 1) chk("rd_after_rst", g, rden_w[g], 1);
        if (rden_w[g]) begin
          chk("rd_expected", g, (ridx[g] < exp_rd.size()), 1);
          chk("rd_overlap", g, cd[g], 0);
          if (ridx[g] < exp_rd.size()) begin
            chk("rd_addr", g, {sel_w[g], maddr_w[g]}, exp_rd[ridx[g]]);
            cap_a[g] = exp_rd[ridx[g]];
            ridx[g]++;
          end
          cd[g] = lat_of(g) + 1;
        end
      end
    end
    if (done && !fin) begin
      for (int g = 0; g < NI; g++) begin
        chk("reads_issued", g, ridx[g], exp_rd.size());
        chk("read_idle", g, cd[g], 0);
      end
      fin = 1'b1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    if (a != addr) exp_rd.push_back(a);
    addr = a;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) ridx[i] = 0;
    for (int i = 0; i < 128; i++) begin
      instr_mem[i] = $urandom;
      data_mem[i]  = $urandom;
    end
    instr_mem[0] = 32'h1234ABCD;
    data_mem[5]  = 32'hFFFF0000;
    instr_mem[5] = 32'h00000000;

    rst = 1'b1; addr = 8'h00;
    step(3);
    exp_rd.push_back(8'h00);
    rst = 1'b0;
    step(200);

    set_addr(8'h05); step(12);
    set_addr(8'h85); step(40);

    set_addr(8'h03); step(1);
    set_addr(8'h04); step(12);

    set_addr(8'h06); step(1);
    addr = 8'h07;    step(1);
    addr = 8'h06;    step(12);

    set_addr(8'h09); step(1);
    rst = 1'b1;      step(3);
    exp_rd.push_back(8'h09);
    rst = 1'b0;      step(12);

    for (int i = 0; i < 30; i++) begin
      set_addr(8'($urandom_range(0, 255)));
      step(10);
    end

    step(8 * SCAN_DIV * 5 + 10);

    done = 1'b1;
    repeat (4) @(posedge clk);
    if (!fin) begin
      errors++;
      $display("FAIL final_checks: got not-run expected run");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
